program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Upstream loader for the 8-bit accumulator CPU.
- Accepts a length-prefixed, checksummed program image over a byte valid/ready stream and writes it into the 32x8 single-port instruction/data memory from address 0.
- Holds the CPU stopped until a good image is loaded, then releases it via cpu_run.
- Owns the memory write path only while cpu_run=0; the top-level muxes memory access on cpu_run.

Parameters:
AWIDTH, 5, memory address width; image holds at most 2**AWIDTH bytes
DWIDTH, 8, memory/stream data width
TIMEOUT, 1023, max clk cycles with no accepted byte while loading before abort; counter width is clog2(TIMEOUT+1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a load
in_valid  input  1  stream byte valid
in_data  input  DWIDTH  stream byte
in_ready  output  1  loader accepts in_data this cycle when in_valid&in_ready
mem_wr  output  1  memory write strobe, one cycle per data byte
mem_addr  output  AWIDTH  memory write address
mem_data  output  DWIDTH  memory write data
cpu_run  output  1  1 = CPU released; 0 = CPU held in reset, loader owns memory
busy  output  1  high in LEN/DATA/CSUM
done  output  1  high in RUN
err  output  1  high in ERR

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; all outputs 0.
  - Byte count, address, checksum and timeout counter cleared.
  - Reset mid-load abandons the load; memory contents already written are not restored.
- Handshake:
  - Byte accepted on a rising edge with in_valid=1 and in_ready=1.
  - in_ready = 1 exactly in LEN, DATA, CSUM; combinational from state only, never from in_valid.
  - Back-to-back accepts at one byte per cycle are supported.
- States:
  - IDLE: start -> LEN.
  - LEN: accepted byte L.
    - L=0 or L>2**AWIDTH -> ERR.
    - Else store count=L, addr=0, sum=0 -> DATA.
  - DATA: each accepted byte b:
    - Next cycle, registered mem_wr=1, mem_addr=addr, mem_data=b.
    - addr+=1; sum=(sum+b) mod 2**DWIDTH.
    - After the L-th byte -> CSUM.
  - CSUM: accepted byte c.
    - c==sum -> RUN.
    - Else -> ERR.
  - RUN: cpu_run=1, done=1. start -> LEN, and cpu_run falls to 0 on that same edge.
  - ERR: err=1, cpu_run=0. start -> LEN (err clears).
- Start handling:
  - start in LEN/DATA/CSUM is ignored.
  - start coincident with reset release is ignored.
- Write timing:
  - mem_wr pulses exactly once per DATA byte, one cycle after acceptance.
  - mem_wr=0 in every other cycle, including when cpu_run=1.
  - The last data write completes in the cycle the loader sits in CSUM or later, so memory is fully written before cpu_run can rise.
  - mem_addr/mem_data hold their last values when mem_wr=0.
- Address width:
  - mem_addr wraps naturally after 2**AWIDTH; never reached, because L is bounded.
  - The internal count is AWIDTH+1 bits so it can hold L=32.
- Timeout:
  - Counter cleared on entering LEN and on every accepted byte.
  - Increments each cycle in LEN/DATA/CSUM with no accept.
  - Reaching TIMEOUT -> ERR on that edge.
  - An accept in the same cycle the count reaches TIMEOUT wins: byte taken, no error.
- Memory not covered by L is untouched.

Test Plan:
- Happy path: rst low then high, start, send 03,A1,B2,C3, then checksum 16 (0xA1+0xB2+0xC3=0x216 -> 0x16). Expect:
  - mem_wr pulses writing addr0=A1, addr1=B2, addr2=C3.
  - done=1 and cpu_run=1 one cycle after the checksum is accepted; err=0.
- Bad checksum: same image, checksum 17. Expect:
  - Three writes still occur.
  - err=1, cpu_run=0; a following start returns to LEN with err=0 and busy=1.
- Length bounds:
  - L=00 -> ERR after one byte, no mem_wr.
  - L=21 (33) -> ERR.
  - L=20 (32) with bytes 00..1F and checksum F0 -> 32 writes to addr 0..31, then RUN.
- Stream stalls and back-to-back: random in_valid gaps under TIMEOUT -> same memory image and RUN; continuous in_valid gives one mem_wr per cycle.
- Timeout: TIMEOUT=15; after accepting L=02 and one data byte, hold in_valid=0 -> ERR exactly 15 cycles after the last accept; no further mem_wr.
- Restart and reset:
  - start while in RUN -> cpu_run falls on the next edge and a new load proceeds.
  - rst asserted in DATA after 2 bytes -> all outputs 0 asynchronously; after release the loader stays in IDLE until start.

Source files
------------

// File: rtl/program_loader_if.sv
// Stream-in / memory-write bundle for the program loader.
// The master modport is the loader's view; slave is the stream source and memory side.
interface program_loader_if #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
);
  logic              in_valid;
  logic [DWIDTH-1:0] in_data;
  logic              in_ready;
  logic              mem_wr;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_data;

  modport master (
    input  in_valid, in_data,
    output in_ready, mem_wr, mem_addr, mem_data
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, mem_wr, mem_addr, mem_data
  );
endinterface

// File: rtl/program_loader.sv
// Loads a length-prefixed, checksummed image from a byte stream into CPU memory,
// then releases the CPU through cpu_run once the checksum matches.
module program_loader #(
  parameter int AWIDTH  = 5,
  parameter int DWIDTH  = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  program_loader_if.master    bus,
  output logic                cpu_run,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int          TW      = $clog2(TIMEOUT + 1);
  localparam int          CW      = AWIDTH + 1;
  localparam int unsigned MAX_LEN = 2 ** AWIDTH;

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CSUM, S_RUN, S_ERR} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] sum_q, sum_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              wr_q, wr_d;
  logic [AWIDTH-1:0] waddr_q, waddr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic              armed_q;
  logic              run_q, busy_q, err_q;
  logic              loading, accept, start_ok, len_bad;

  assign loading      = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign bus.in_ready = loading;
  assign accept       = bus.in_valid & loading;
  // armed_q is low for the first edge after reset release, masking a start held across it
  assign start_ok     = start & armed_q;
  assign len_bad      = (bus.in_data == '0) || (32'(bus.in_data) > MAX_LEN);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    sum_d   = sum_q;
    tmo_d   = tmo_q;
    wr_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;

    if (loading) tmo_d = accept ? '0 : tmo_q + 1'b1;

    unique case (state_q)
      S_IDLE, S_RUN, S_ERR: begin
        if (start_ok) begin
          state_d = S_LEN;
          tmo_d   = '0;
        end
      end
      S_LEN: begin
        if (accept) begin
          if (len_bad) begin
            state_d = S_ERR;
          end else begin
            cnt_d   = bus.in_data[CW-1:0];
            addr_d  = '0;
            sum_d   = '0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          wr_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = bus.in_data;
          addr_d  = addr_q + 1'b1;
          sum_d   = sum_q + bus.in_data;
          cnt_d   = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (accept) state_d = (bus.in_data == sum_q) ? S_RUN : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase

    // A byte accepted in the expiring cycle keeps the load alive.
    if (loading && !accept && tmo_d == TW'(TIMEOUT)) state_d = S_ERR;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      sum_q   <= '0;
      tmo_q   <= '0;
      wr_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      armed_q <= 1'b0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      sum_q   <= sum_d;
      tmo_q   <= tmo_d;
      wr_q    <= wr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      armed_q <= 1'b1;
      run_q   <= (state_d == S_RUN);
      busy_q  <= (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
      err_q   <= (state_d == S_ERR);
    end
  end

  assign bus.mem_wr   = wr_q;
  assign bus.mem_addr = waddr_q;
  assign bus.mem_data = wdata_q;
  assign cpu_run      = run_q;
  assign done         = run_q;
  assign busy         = busy_q;
  assign err          = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed image table, timeout and reset
// corner cases, then random images against a behavioural memory/outcome model.
module tb_program_loader;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic cpu_run, busy, done, err;

  program_loader_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  program_loader #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bus     (bus),
    .cpu_run (cpu_run),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0] addr;
    logic [7:0] data;
    int         cyc;
  } wr_t;

  wr_t        wlog[$];
  int         cyc = 0;
  int         wr_run_bad = 0;
  logic [7:0] tb_mem  [32] = '{default: 8'h00};
  logic [7:0] mem_exp [32] = '{default: 8'h00};
  logic [7:0] cur_data[32];
  logic [7:0] fixed_img[3] = '{8'hA1, 8'hB2, 8'hC3};

  // Memory model fed by the DUT's write port.
  always @(negedge clk) begin
    cyc++;
    if (bus.mem_wr === 1'b1) begin
      wlog.push_back('{bus.mem_addr, bus.mem_data, cyc});
      tb_mem[bus.mem_addr] = bus.mem_data;
      if (cpu_run) wr_run_bad++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int mem_mismatch();
    int m = 0;
    for (int i = 0; i < 32; i++) if (tb_mem[i] !== mem_exp[i]) m++;
    return m;
  endfunction

  function automatic int pick_gap(input int max_gap);
    if (max_gap == 0) return 0;
    return int'($urandom_range(0, max_gap));
  endfunction

  // Entered and left on a falling edge; the byte is accepted on the rising edge in between.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("ready_wait", 0, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_load(input logic [7:0] len, input logic [7:0] csum, input int max_gap,
                          input logic exp_run, input int exp_wr);
    int base;
    int n;
    int seq_bad;
    bit valid;
    base = wlog.size();
    pulse_start();
    check("start_state", int'({busy, cpu_run, done, err, bus.in_ready}), 5'b10001);
    send_byte(len, pick_gap(max_gap));
    valid = (len != 8'd0) && (len <= 8'd32);
    if (valid) begin
      for (int i = 0; i < int'(len); i++) begin
        send_byte(cur_data[i], pick_gap(max_gap));
        mem_exp[i] = cur_data[i];
      end
      send_byte(csum, pick_gap(max_gap));
    end
    check("outcome", int'({busy, bus.in_ready, cpu_run, done, err}),
          int'({2'b00, exp_run, exp_run, ~exp_run}));
    #1;
    n = wlog.size() - base;
    check("wr_count", n, exp_wr);
    seq_bad = 0;
    for (int i = 0; i < n && i < 32; i++)
      if (wlog[base+i].addr !== 5'(i) || wlog[base+i].data !== cur_data[i]) seq_bad++;
    check("wr_seq", seq_bad, 0);
    if (max_gap == 0 && n > 1) check("back_to_back", wlog[base+n-1].cyc - wlog[base].cyc, n - 1);
    check("mem_image", mem_mismatch(), 0);
  endtask

  typedef struct {
    logic [7:0] len;
    int         pat;
    logic [7:0] csum;
    logic       exp_run;
    int         exp_wr;
    int         max_gap;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int base;
    vecs[0] = '{8'h03, 0, 8'h16, 1'b1, 3,  0};
    vecs[1] = '{8'h03, 0, 8'h17, 1'b0, 3,  0};
    vecs[2] = '{8'h00, 0, 8'h00, 1'b0, 0,  0};
    vecs[3] = '{8'h21, 0, 8'h00, 1'b0, 0,  0};
    vecs[4] = '{8'h20, 1, 8'hF0, 1'b1, 32, 0};
    vecs[5] = '{8'h01, 1, 8'h00, 1'b1, 1,  2};
    vecs[6] = '{8'h02, 1, 8'h01, 1'b1, 2,  3};
    vecs[7] = '{8'h03, 0, 8'h16, 1'b1, 3,  3};

    rst = 1'b0;
    start = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_outs", int'({cpu_run, busy, done, err, bus.in_ready, bus.mem_wr}), 0);

    // start held across reset release must not begin a load
    rst = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_at_release", int'({busy, bus.in_ready}), 0);
    @(negedge clk);
    check("idle_hold", int'({busy, cpu_run, done, err}), 0);

    foreach (vecs[v]) begin
      for (int i = 0; i < 32; i++)
        cur_data[i] = (vecs[v].pat == 0) ? ((i < 3) ? fixed_img[i] : 8'h00) : 8'(i);
      run_load(vecs[v].len, vecs[v].csum, vecs[v].max_gap, vecs[v].exp_run, vecs[v].exp_wr);
    end

    // Timeout: ERR exactly TO cycles after the last accepted byte.
    base = wlog.size();
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h5A, 0);
    mem_exp[0] = 8'h5A;
    k = 0;
    while (k < TO + 5) begin
      @(negedge clk);
      k++;
      if (err) break;
    end
    check("timeout_cycles", k, TO);
    #1;
    check("timeout_writes", wlog.size() - base, 1);
    check("timeout_mem", mem_mismatch(), 0);
    check("timeout_ready", int'(bus.in_ready), 0);

    // A byte accepted in the expiring cycle wins over the timeout.
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, TO - 1);
    send_byte(8'h33, TO - 1);
    mem_exp[0] = 8'h11;
    mem_exp[1] = 8'h22;
    check("accept_wins", int'({cpu_run, done, err}), 3'b110);

    // Reset mid-DATA clears outputs asynchronously; loader then waits in IDLE.
    pulse_start();
    send_byte(8'h05, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    mem_exp[0] = 8'h01;
    mem_exp[1] = 8'h02;
    #2;
    rst = 1'b0;
    #1;
    check("async_rst", int'({cpu_run, busy, done, err, bus.in_ready, bus.mem_wr}), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_rst", int'({busy, bus.in_ready, cpu_run, err}), 0);
    #1;
    check("rst_mem", mem_mismatch(), 0);

    // Random images against the behavioural model.
    for (int t = 0; t < 30; t++) begin
      logic [7:0] len;
      logic [7:0] s;
      logic [7:0] cs;
      bit         good;
      bit         valid;
      int         sel;
      sel = int'($urandom_range(0, 19));
      if (sel == 0)      len = 8'h00;
      else if (sel == 1) len = 8'($urandom_range(33, 255));
      else               len = 8'($urandom_range(1, 32));
      s = 8'h00;
      for (int i = 0; i < 32; i++) begin
        cur_data[i] = 8'($urandom);
        if (i < int'(len)) s = s + cur_data[i];
      end
      good  = ($urandom_range(0, 3) != 0);
      cs    = good ? s : s + 8'($urandom_range(1, 255));
      valid = (len >= 8'd1) && (len <= 8'd32);
      run_load(len, cs, (t % 3 == 0) ? 0 : 3, valid && good, valid ? int'(len) : 0);
    end

    check("wr_during_run", wr_run_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
